inv_key_schedule: RTL and testbench
===================================

// Module: inv_key_schedule
// PURPOSE
//   AES-128 key schedule that feeds the decryption round datapath. Expands a 128-bit cipher key
//   into 11 round keys (rk0..rk10), one per cycle, then serves them in reverse order (rk10 first).
//   The round controller pulses round_req once per decryption round to step to the next key.
//   Sits directly upstream of the per-round keyAdd stage; round_key drives its key input.
// PARAMETERS
//   NUM_ROUNDS  10   rounds after initial AddRoundKey; round-key array holds NUM_ROUNDS+1 entries
//   KEY_W       128  key/round-key width in bits; only 128 is supported
// PORTS
//   clk          in   1    system clock, rising edge
//   rst          in   1    asynchronous, active-high reset
//   key_load     in   1    1-cycle pulse: capture cipher_key and start expansion
//   cipher_key   in   128  cipher key; word0 = [127:96], byte0 = [127:120]
//   round_req    in   1    1-cycle pulse: current round key consumed, advance to next (lower) index
//   round_key    out  128  rk[round_idx] while key_valid, else 0
//   round_idx    out  4    index of the key on round_key (10 down to 0)
//   key_valid    out  1    round_key is valid
//   busy         out  1    expansion in progress
//   sched_done   out  1    1-cycle pulse when rk0 is consumed
// BEHAVIOUR
//   Reset: state=IDLE; key_valid=0, busy=0, sched_done=0, round_idx=0, round_key=0; rk array all 0.
//   FSM states: IDLE, EXPAND, READY.
//   IDLE:   key_load -> rk0<=cipher_key, exp_cnt<=1, EXPAND. round_req ignored.
//   EXPAND: busy=1; each cycle rk[exp_cnt] <= f(rk[exp_cnt-1], RCON[exp_cnt-1]); exp_cnt++.
//           After rk10 is written -> READY, round_idx<=10, key_valid<=1.
//           Latency: key_valid rises 11 edges after the edge that samples key_load.
//   Step f: t = SubWord(RotWord(w3)) ^ {RCON,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//   READY:  round_key = rk[round_idx]. round_req with round_idx>0 -> round_idx--, effective next cycle.
//           round_req with round_idx==0 -> sched_done=1 for 1 cycle; end-of-schedule action per CONFIGURATION.
//   key_load has priority over round_req in every state. key_load in EXPAND or READY restarts
//     expansion from the new key: key_valid drops next cycle; the old schedule is discarded.
//   round_req in IDLE/EXPAND: ignored, no error flag. Back-to-back round_req: one step per cycle.
//   round_idx never wraps below 0. Async rst mid-expansion: immediate return to reset state.
// CONFIGURATION
//   Macro KEYSCHED_ZEROIZE_EN:
//   defined:   consuming rk0 clears all rk entries to 0 in the same cycle as sched_done.
//              Next state is IDLE; key_valid=0; round_idx=0. A new key_load is required.
//   undefined: consuming rk0 rewinds round_idx to 10; stays READY with key_valid=1.
//              The next block decrypts with the same schedule, no re-expansion.
// STRUCTURE
//   Package aes_pkg: RCON[0:9] = 01,02,04,08,10,20,40,80,1b,36; enum ks_state_t {IDLE,EXPAND,READY};
//     localparam NUM_RK = NUM_ROUNDS+1.
//   Sub-module key_expand_step (combinational): implements f.
//     Inputs: prev key and rcon byte. Output: next key.
//     Uses 4 forward S-box byte instances.
//   Top level: FSM, exp_cnt, round_idx counter, rk register array.
// TESTING
//   1 key 2b7e151628aed2a6abf7158809cf4f3c, key_load -> key_valid after 11 edges.
//     round_idx=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
//   2 key 000102030405060708090a0b0c0d0e0f -> rk10=13111d7fe3944a17f307a78b4d2b30c5.
//     10 round_req pulses -> round_key=000102030405060708090a0b0c0d0e0f, round_idx=0.
//   3 Same key, 11th round_req -> sched_done pulses once.
//     Without the macro: round_idx=10, rk10 returned.
//     With KEYSCHED_ZEROIZE_EN: key_valid=0, state IDLE.
//   4 key_load at EXPAND cycle 5 with key 2b7e...4f3c -> busy stays 1.
//     key_valid 11 edges later; round_key=d014...0ca6.
//   5 key_load and round_req in the same cycle in READY -> expansion restarts, no index step.
//   6 rst asserted asynchronously mid-EXPAND and mid-READY -> all outputs 0 immediately.
//     round_req in IDLE is ignored.

Source files
------------

// File: rtl/inv_key_schedule_pkg.sv
// Shared definitions for the AES-128 inverse-order key schedule:
// round count, key width, round constants, FSM states and the forward S-box.
package inv_key_schedule_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;
  localparam int NUM_RK     = NUM_ROUNDS + 1;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_t;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward S-box lookup for one byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for expansion step i (0..9); out-of-range steps yield 0.
  function automatic logic [7:0] rcon_byte(input logic [3:0] i);
    return (i < 4'd10) ? RCON[i] : 8'h00;
  endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Key-schedule bus between the round controller (master) and the
// key schedule (slave): load/step requests in, round key and status out.
interface inv_key_schedule_if;
  import inv_key_schedule_pkg::*;

  logic             key_load;
  logic [KEY_W-1:0] cipher_key;
  logic             round_req;
  logic [KEY_W-1:0] round_key;
  logic [3:0]       round_idx;
  logic             key_valid;
  logic             busy;
  logic             sched_done;

  modport master (
    output key_load, cipher_key, round_req,
    input  round_key, round_idx, key_valid, busy, sched_done
  );

  modport slave (
    input  key_load, cipher_key, round_req,
    output round_key, round_idx, key_valid, busy, sched_done
  );

endinterface

// File: rtl/inv_key_schedule_expand_step.sv
// One AES-128 key expansion step: next round key from the previous one
// and the round constant. Purely combinational, four S-box byte lookups.
module inv_key_schedule_expand_step import inv_key_schedule_pkg::*; (
  input  logic [KEY_W-1:0] i_prev,
  input  logic [7:0]       i_rcon,
  output logic [KEY_W-1:0] o_next
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  // RotWord of the last word: byte order a0a1a2a3 -> a1a2a3a0
  assign w_rot = {i_prev[23:0], i_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign w_sub[8*g +: 8] = sbox(w_rot[8*g +: 8]);
  end

  assign w_t  = w_sub ^ {i_rcon, 24'h000000};
  assign w_n0 = i_prev[127:96] ^ w_t;
  assign w_n1 = i_prev[95:64]  ^ w_n0;
  assign w_n2 = i_prev[63:32]  ^ w_n1;
  assign w_n3 = i_prev[31:0]   ^ w_n2;

  assign o_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 key schedule for decryption: expands the cipher key into rk0..rk10
// one key per cycle, then presents them from rk10 down to rk0 on round_req.
// Optional feature macro KEYSCHED_ZEROIZE_EN: when defined, consuming rk0 wipes
// the key store and returns to IDLE; otherwise the index rewinds to rk10 and
// the same schedule is reused for the next block.
module inv_key_schedule import inv_key_schedule_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  inv_key_schedule_if.slave bus
);

  ks_state_t        r_state;
  logic [3:0]       r_exp_cnt;
  logic [3:0]       r_round_idx;
  logic             r_key_valid;
  logic             r_busy;
  logic             r_sched_done;
  logic [KEY_W-1:0] r_rk [NUM_RK];

  logic [3:0]       w_prev_idx;
  logic [KEY_W-1:0] w_prev;
  logic [7:0]       w_rcon;
  logic [KEY_W-1:0] w_next;

  // Expansion source is rk[exp_cnt-1]; clamp so IDLE (exp_cnt=0) never indexes out of range
  assign w_prev_idx = (r_exp_cnt == 4'd0) ? 4'd0 : r_exp_cnt - 4'd1;
  assign w_prev     = r_rk[w_prev_idx];
  assign w_rcon     = rcon_byte(w_prev_idx);

  inv_key_schedule_expand_step u_step (
    .i_prev (w_prev),
    .i_rcon (w_rcon),
    .o_next (w_next)
  );

  // Control FSM with key store: load, expand one key per cycle, then serve in reverse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_exp_cnt    <= 4'd0;
      r_round_idx  <= 4'd0;
      r_key_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_sched_done <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
    end else begin
      r_sched_done <= 1'b0;
      if (bus.key_load) begin
        // A new key always wins and discards whatever schedule was in flight
        r_rk[0]     <= bus.cipher_key;
        r_exp_cnt   <= 4'd1;
        r_round_idx <= 4'd0;
        r_key_valid <= 1'b0;
        r_busy      <= 1'b1;
        r_state     <= EXPAND;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          EXPAND: begin
            if (r_exp_cnt == 4'(NUM_RK)) begin
              r_state     <= READY;
              r_busy      <= 1'b0;
              r_key_valid <= 1'b1;
              r_round_idx <= 4'(NUM_ROUNDS);
            end else begin
              r_rk[r_exp_cnt] <= w_next;
              r_exp_cnt       <= r_exp_cnt + 4'd1;
            end
          end
          READY: begin
            if (bus.round_req) begin
              if (r_round_idx != 4'd0) begin
                r_round_idx <= r_round_idx - 4'd1;
              end else begin
                r_sched_done <= 1'b1;
`ifdef KEYSCHED_ZEROIZE_EN
                for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
                r_state     <= IDLE;
                r_key_valid <= 1'b0;
                r_round_idx <= 4'd0;
                r_exp_cnt   <= 4'd0;
`else
                r_round_idx <= 4'(NUM_ROUNDS);
`endif
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.round_key  = r_key_valid ? r_rk[r_round_idx] : '0;
  assign bus.round_idx  = r_round_idx;
  assign bus.key_valid  = r_key_valid;
  assign bus.busy       = r_busy;
  assign bus.sched_done = r_sched_done;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed and randomized bench for inv_key_schedule. The reference model
// builds the S-box from GF(2^8) inversion plus the affine map and expands
// keys word-by-word, independent of the design's table and datapath.
module tb_inv_key_schedule;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inv_key_schedule_if bus();

  inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   m_sbox [256];
  logic [127:0] ref_rk [11];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
  endfunction

  // FIPS-197 style word expansion: w[i] = w[i-4] ^ temp
  task automatic build_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc   = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.cipher_key = k;
    bus.key_load   = 1'b1;
    tick();
    bus.key_load   = 1'b0;
  endtask

  // Edges until key_valid (bounded); also flags any cycle where busy dropped early
  task automatic wait_valid(output int n, output bit drop);
    n    = 0;
    drop = 1'b0;
    while (!bus.key_valid && n < 20) begin
      tick();
      n++;
      if (!bus.key_valid && !bus.busy) drop = 1'b1;
    end
  endtask

  int   n;
  bit   drop;
  int   exp_idx;
  bit   exp_valid;
  bit   exp_done;
  int   reqs;
  bit   go;
  logic [127:0] kr;

  initial begin
    bus.key_load   = 1'b0;
    bus.round_req  = 1'b0;
    bus.cipher_key = '0;
    init_sbox();
    #12;
    chk("rst_valid", 128'(bus.key_valid), 128'd0);
    chk("rst_busy",  128'(bus.busy),      128'd0);
    chk("rst_done",  128'(bus.sched_done), 128'd0);
    chk("rst_idx",   128'(bus.round_idx), 128'd0);
    chk("rst_key",   bus.round_key,       128'd0);
    tick();
    rst = 1'b0;

    // Test 1: FIPS key, latency of exactly 11 edges
    load_key(K1);
    chk("t1_busy_e0", 128'(bus.busy), 128'd1);
    for (int i = 1; i <= 10; i++) tick();
    chk("t1_valid_e10", 128'(bus.key_valid), 128'd0);
    chk("t1_busy_e10",  128'(bus.busy),      128'd1);
    tick();
    chk("t1_valid_e11", 128'(bus.key_valid), 128'd1);
    chk("t1_busy_e11",  128'(bus.busy),      128'd0);
    chk("t1_idx",       128'(bus.round_idx), 128'd10);
    chk("t1_rk10",      bus.round_key,       K1_R10);

    // Test 2: back-to-back round_req walks rk10 down to rk0
    build_ref(K2);
    load_key(K2);
    wait_valid(n, drop);
    chk("t2_latency", 128'(n), 128'd11);
    chk("t2_rk10", bus.round_key, K2_R10);
    bus.round_req = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      tick();
      chk($sformatf("t2_idx%0d", i), 128'(bus.round_idx), 128'(i));
      chk($sformatf("t2_rk%0d", i),  bus.round_key,       ref_rk[i]);
    end
    bus.round_req = 1'b0;
    chk("t2_rk0_const", bus.round_key, K2);

    // Test 3: consuming rk0 ends the schedule
    bus.round_req = 1'b1;
    tick();
    bus.round_req = 1'b0;
    chk("t3_done", 128'(bus.sched_done), 128'd1);
`ifdef KEYSCHED_ZEROIZE_EN
    chk("t3_valid", 128'(bus.key_valid), 128'd0);
    chk("t3_idx",   128'(bus.round_idx), 128'd0);
    chk("t3_key",   bus.round_key,       128'd0);
`else
    chk("t3_valid", 128'(bus.key_valid), 128'd1);
    chk("t3_idx",   128'(bus.round_idx), 128'd10);
    chk("t3_key",   bus.round_key,       K2_R10);
`endif
    tick();
    chk("t3_done_clr", 128'(bus.sched_done), 128'd0);
`ifdef KEYSCHED_ZEROIZE_EN
    bus.round_req = 1'b1;
    tick();
    bus.round_req = 1'b0;
    chk("t3_idle_req_valid", 128'(bus.key_valid), 128'd0);
    chk("t3_idle_req_done",  128'(bus.sched_done), 128'd0);
`endif

    // Test 4: reload during expansion cycle 5
    load_key(K2);
    for (int i = 1; i <= 4; i++) tick();
    load_key(K1);
    chk("t4_busy", 128'(bus.busy), 128'd1);
    wait_valid(n, drop);
    chk("t4_latency",   128'(n),    128'd11);
    chk("t4_busy_drop", 128'(drop), 128'd0);
    chk("t4_rk10",      bus.round_key, K1_R10);

    // Test 5: key_load and round_req together in READY
    bus.round_req = 1'b1;
    tick();
    bus.round_req = 1'b0;
    chk("t5_step", 128'(bus.round_idx), 128'd9);
    kr = {$urandom(), $urandom(), $urandom(), $urandom()};
    build_ref(kr);
    bus.cipher_key = kr;
    bus.key_load   = 1'b1;
    bus.round_req  = 1'b1;
    tick();
    bus.key_load   = 1'b0;
    bus.round_req  = 1'b0;
    chk("t5_valid_drop", 128'(bus.key_valid), 128'd0);
    chk("t5_busy",       128'(bus.busy),      128'd1);
    wait_valid(n, drop);
    chk("t5_latency", 128'(n), 128'd11);
    chk("t5_idx",     128'(bus.round_idx), 128'd10);
    chk("t5_rk10",    bus.round_key,       ref_rk[10]);

    // Randomized keys with randomly gapped round_req, scoreboarded per cycle
    for (int r = 0; r < 3; r++) begin
      kr = {$urandom(), $urandom(), $urandom(), $urandom()};
      build_ref(kr);
      load_key(kr);
      wait_valid(n, drop);
      chk($sformatf("rnd%0d_latency", r), 128'(n), 128'd11);
      exp_idx   = 10;
      exp_valid = 1'b1;
      reqs      = 0;
      for (int c = 0; c < 80 && reqs < 11; c++) begin
        go            = 1'($urandom_range(0, 1));
        bus.round_req = go;
        tick();
        bus.round_req = 1'b0;
        exp_done      = 1'b0;
        if (go) begin
          reqs++;
          if (exp_idx > 0) exp_idx--;
          else begin
            exp_done = 1'b1;
`ifdef KEYSCHED_ZEROIZE_EN
            exp_valid = 1'b0;
            exp_idx   = 0;
`else
            exp_idx   = 10;
`endif
          end
        end
        chk($sformatf("rnd%0d_c%0d_idx", r, c),  128'(bus.round_idx), 128'(exp_idx));
        chk($sformatf("rnd%0d_c%0d_done", r, c), 128'(bus.sched_done), 128'(exp_done));
        chk($sformatf("rnd%0d_c%0d_key", r, c),  bus.round_key, exp_valid ? ref_rk[exp_idx] : 128'd0);
      end
      chk($sformatf("rnd%0d_reqs", r), 128'(reqs), 128'd11);
    end

    // Test 6: async reset mid-EXPAND, round_req in IDLE, async reset mid-READY
    load_key({$urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6a_busy",  128'(bus.busy),      128'd0);
    chk("t6a_valid", 128'(bus.key_valid), 128'd0);
    chk("t6a_idx",   128'(bus.round_idx), 128'd0);
    chk("t6a_key",   bus.round_key,       128'd0);
    tick();
    rst = 1'b0;
    bus.round_req = 1'b1;
    tick();
    bus.round_req = 1'b0;
    chk("t6_idle_req_valid", 128'(bus.key_valid), 128'd0);
    chk("t6_idle_req_busy",  128'(bus.busy),      128'd0);
    chk("t6_idle_req_idx",   128'(bus.round_idx), 128'd0);
    load_key(K1);
    wait_valid(n, drop);
    chk("t6_ready", 128'(bus.key_valid), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6b_valid", 128'(bus.key_valid), 128'd0);
    chk("t6b_idx",   128'(bus.round_idx), 128'd0);
    chk("t6b_key",   bus.round_key,       128'd0);
    chk("t6b_done",  128'(bus.sched_done), 128'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
